q1_bit_packer: RTL

//  Downstream consumer of the registered serial output q1 of the upstream capture stage.

---
 rtl/q1_bit_packer_pkg.sv | 12 +
 rtl/q1_bit_packer_sat_counter.sv | 36 +++
 rtl/q1_bit_packer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/q1_bit_packer_pkg.sv
// Package sta_pkg: shared types and default sizing for the q1 bit packer.
//   out_state_e : output register occupancy (EMPTY / FULL)
//   WORD_W_DEF  : default packed word width
//   CNT_W_DEF   : default drop counter width
package sta_pkg;

    typedef enum logic {EMPTY, FULL} out_state_e;

    localparam int WORD_W_DEF = 8;
    localparam int CNT_W_DEF  = 8;

endpackage

// File: rtl/q1_bit_packer_sat_counter.sv
// Module sat_counter: up-counter that sticks at all-ones.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears the count
//   inc   : count up by one this cycle (ignored once saturated)
//   cnt   : current count
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: state flops use non-blocking assignment so every flop samples
    // pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/q1_bit_packer.sv
// Module q1_bit_packer: packs qualified serial bits (LSB first) into words and
// presents them on a one-entry valid/ready output register.
//   clk, rst_n  : rising-edge clock, asynchronous active-low reset
//   bit_in      : serial data bit
//   bit_en      : bit_in is valid this cycle
//   flush       : emit the partial word now (a same-cycle bit is included)
//   word_data   : packed word, bit i = i-th bit received, unfilled bits 0
//   word_len    : number of valid bits in word_data (1..WORD_W)
//   word_valid  : output register holds a word
//   word_ready  : consumer takes the word this cycle
//   drop_cnt    : saturating count of words lost to backpressure
//   overflow    : sticky, at least one word was dropped
module q1_bit_packer
    import sta_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int LEN_W  = 4,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_in,
    input  logic              bit_en,
    input  logic              flush,
    output logic [WORD_W-1:0] word_data,
    output logic [LEN_W-1:0]  word_len,
    output logic              word_valid,
    input  logic              word_ready,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic              overflow
);

    // Collector
    logic [WORD_W-1:0] sh_q, sh_d;
    logic [LEN_W-1:0]  bcnt_q, bcnt_d;
    logic [WORD_W-1:0] cand;
    logic [LEN_W-1:0]  len_new;
    logic              complete;

    // Output register
    out_state_e        state_q, state_d;
    logic [WORD_W-1:0] word_data_q, word_data_d;
    logic [LEN_W-1:0]  word_len_q, word_len_d;
    logic              overflow_q, overflow_d;
    logic              drop;

    // NOTE: every always_comb output gets a default before any branch, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        // The shift register is cleared on each completion and filled in
        // order, so bits above bcnt are already zero: OR-ing the new bit in
        // yields the candidate with unfilled bits forced to 0.
        cand     = sh_q | ({{(WORD_W-1){1'b0}}, bit_in & bit_en} << bcnt_q);
        len_new  = bcnt_q + {{(LEN_W-1){1'b0}}, bit_en};
        complete = (bit_en && (bcnt_q == LEN_W'(WORD_W - 1)))
                 || (flush && ((bcnt_q != '0) || bit_en));

        sh_d   = sh_q;
        bcnt_d = bcnt_q;
        if (complete) begin
            sh_d   = '0;
            bcnt_d = '0;
        end else if (bit_en) begin
            sh_d   = cand;
            bcnt_d = len_new;
        end
    end

    always_comb begin
        state_d     = state_q;
        word_data_d = word_data_q;
        word_len_d  = word_len_q;
        overflow_d  = overflow_q;
        drop        = 1'b0;

        case (state_q)
            EMPTY: begin
                if (complete) begin
                    word_data_d = cand;
                    word_len_d  = len_new;
                    state_d     = FULL;
                end
            end
            FULL: begin
                if (word_ready) begin
                    // A same-cycle completion reloads behind the accepted word
                    // with no empty cycle in between.
                    if (complete) begin
                        word_data_d = cand;
                        word_len_d  = len_new;
                    end else begin
                        state_d = EMPTY;
                    end
                end else if (complete) begin
                    // Held word stays put; the new word is lost.
                    drop       = 1'b1;
                    overflow_d = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q        <= '0;
            bcnt_q      <= '0;
            state_q     <= EMPTY;
            word_data_q <= '0;
            word_len_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            sh_q        <= sh_d;
            bcnt_q      <= bcnt_d;
            state_q     <= state_d;
            word_data_q <= word_data_d;
            word_len_q  <= word_len_d;
            overflow_q  <= overflow_d;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_drop_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (drop),
        .cnt   (drop_cnt)
    );

    assign word_data  = word_data_q;
    assign word_len   = word_len_q;
    assign word_valid = (state_q == FULL);
    assign overflow   = overflow_q;

endmodule
